pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program counter with RUN/HALTED/STEP control, conditional jump decode and a
// saturating advance counter. All outputs are registered.
module pc_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_instr,
  input  logic [2:0]  jmp,
  input  logic        zr,
  input  logic        ng,
  input  logic [15:0] a_reg,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic        resume,
  output logic [15:0] pc,
  output logic        halted,
  output logic        jump_taken,
  output logic [15:0] instr_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_RESET  = START_HALTED ? ST_HALTED : ST_RUN;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        take;
  logic        adv;
  logic [15:0] pc_nxt;

  function automatic logic jump_cond(input logic [2:0] j, input logic z, input logic n);
    logic c;
    case (j)
      3'b000:  c = 1'b0;
      3'b001:  c = !z && !n;
      3'b010:  c = z;
      3'b011:  c = z || !n;
      3'b100:  c = n;
      3'b101:  c = !z;
      3'b110:  c = z || n;
      default: c = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    take      = c_instr && jump_cond(jmp, zr, ng);
    pc_nxt    = take ? a_reg : pc + 16'd1;
    adv       = 1'b0;
    state_nxt = state;
    case (state)
      ST_RUN: begin
        // halt takes precedence over any jump presented in the same cycle
        if (halt_req) state_nxt = ST_HALTED;
        else          adv       = 1'b1;
      end
      ST_HALTED: begin
        if (resume)        state_nxt = ST_RUN;
        else if (step_req) state_nxt = ST_STEP;
      end
      ST_STEP: begin
        adv       = 1'b1;
        state_nxt = resume ? ST_RUN : ST_HALTED;
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  // state / output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RESET;
      halted      <= START_HALTED;
      pc          <= RESET_VECTOR;
      jump_taken  <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      state      <= state_nxt;
      halted     <= (state_nxt == ST_HALTED);
      jump_taken <= adv && take;
      if (adv) begin
        pc          <= pc_nxt;
        instr_count <= sat_inc(instr_count);
      end
    end
  end

endmodule
